clip_obj_fetch: RTL and testbench

Downstream consumer of the video object memory's clip read port. On start, it walks object slots 0..N-1 and issues one-cycle-latency reads. Each object is trivially rejected if it lies fully off-screen, or skipped if its slot is empty. Surviving objects go to the rasterizer over a valid/ready handshake, each with a screen bounding box.

---
 rtl/clip_obj_fetch.sv | 180 ++++++++++++++++++
 tb/tb_clip_obj_fetch.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clip_obj_fetch.sv
// clip_obj_fetch: walks the object memory's clip read port, rejects objects
// that are fully off-screen, skips empty slots, and hands the survivors to the
// rasterizer over a valid/ready handshake, each with a screen bounding box.
// Build option: define CLIP_CLAMP_EN to saturate the bounding box to the screen.
module clip_obj_fetch #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [5:0]   obj_count,
    output logic [4:0]   clip_addr,
    output logic         clip_rd_en,
    input  logic [143:0] clip_obj_in,
    output logic         obj_valid,
    input  logic         obj_ready,
    output logic [143:0] obj_data,
    output logic [15:0]  bbox_xmin,
    output logic [15:0]  bbox_xmax,
    output logic [15:0]  bbox_ymin,
    output logic [15:0]  bbox_ymax,
    output logic         busy,
    output logic         done,
    output logic [5:0]   accept_cnt,
    output logic [5:0]   reject_cnt
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_OUT     = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic signed [15:0] X_LIM = 16'(SCREEN_W);
    localparam logic signed [15:0] Y_LIM = 16'(SCREEN_H);

    logic [2:0] state;
    logic [4:0] idx;
    logic [5:0] count;

    logic signed [15:0] xv [4];
    logic signed [15:0] yv [4];
    logic signed [15:0] xmin, xmax, ymin, ymax;
    logic signed [15:0] xmin_o, xmax_o, ymin_o, ymax_o;
    logic               is_empty, is_reject, is_last;

    // Saturate a signed coordinate into [0, hi-1].
    function automatic logic signed [15:0] sat(input logic signed [15:0] v,
                                              input logic signed [15:0] hi);
        if (v < 16'sd0)
            sat = 16'sd0;
        else if (v >= hi)
            sat = hi - 16'sd1;
        else
            sat = v;
    endfunction

    // Unpack the four vertices and reduce them to a signed bounding box.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            xv[i] = clip_obj_in[32*i +: 16];
            yv[i] = clip_obj_in[32*i+16 +: 16];
        end
        xmin = xv[0];
        xmax = xv[0];
        ymin = yv[0];
        ymax = yv[0];
        for (int i = 1; i < 4; i++) begin
            if (xv[i] < xmin) xmin = xv[i];
            if (xv[i] > xmax) xmax = xv[i];
            if (yv[i] < ymin) ymin = yv[i];
            if (yv[i] > ymax) ymax = yv[i];
        end
    end

    // Classification: all vertices on one outer side of the screen is
    // equivalent to the box extreme on that side lying off-screen.
    always_comb begin
        is_empty  = (clip_obj_in[143:140] == 4'd0);
        is_reject = (xmax < 16'sd0) || (xmin >= X_LIM) ||
                    (ymax < 16'sd0) || (ymin >= Y_LIM);
        is_last   = ({1'b0, idx} == count - 6'd1);
    end

`ifdef CLIP_CLAMP_EN
    // Clamp the bounds to the visible area before they are registered.
    always_comb begin
        xmin_o = sat(xmin, X_LIM);
        xmax_o = sat(xmax, X_LIM);
        ymin_o = sat(ymin, Y_LIM);
        ymax_o = sat(ymax, Y_LIM);
    end
`else
    // Raw signed bounds are forwarded unchanged.
    always_comb begin
        xmin_o = xmin;
        xmax_o = xmax;
        ymin_o = ymin;
        ymax_o = ymax;
    end
`endif

    // Outputs decoded directly from the state.
    always_comb begin
        clip_rd_en = (state == S_FETCH);
        clip_addr  = clip_rd_en ? idx : 5'd0;
        obj_valid  = (state == S_OUT);
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
    end

    // Pass sequencer, counters and the registered object/bbox.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            idx        <= 5'd0;
            count      <= 6'd0;
            accept_cnt <= 6'd0;
            reject_cnt <= 6'd0;
            obj_data   <= '0;
            bbox_xmin  <= 16'd0;
            bbox_xmax  <= 16'd0;
            bbox_ymin  <= 16'd0;
            bbox_ymax  <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        count      <= (obj_count > 6'd32) ? 6'd32 : obj_count;
                        idx        <= 5'd0;
                        accept_cnt <= 6'd0;
                        reject_cnt <= 6'd0;
                        state      <= (obj_count == 6'd0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: begin
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (!is_empty && !is_reject) begin
                        obj_data   <= clip_obj_in;
                        bbox_xmin  <= xmin_o;
                        bbox_xmax  <= xmax_o;
                        bbox_ymin  <= ymin_o;
                        bbox_ymax  <= ymax_o;
                        accept_cnt <= accept_cnt + 6'd1;
                        state      <= S_OUT;
                    end else begin
                        if (!is_empty)
                            reject_cnt <= reject_cnt + 6'd1;
                        if (is_last) begin
                            state <= S_DONE;
                        end else begin
                            idx   <= idx + 5'd1;
                            state <= S_FETCH;
                        end
                    end
                end
                S_OUT: begin
                    if (obj_ready) begin
                        if (is_last) begin
                            state <= S_DONE;
                        end else begin
                            idx   <= idx + 5'd1;
                            state <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clip_obj_fetch.sv
// Testbench for clip_obj_fetch: directed passes over a bench-side object
// memory, checked against a queue-based model of which objects must emerge.
module tb_clip_obj_fetch;

    localparam int W = 640;
    localparam int H = 480;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [5:0]   obj_count;
    logic [4:0]   clip_addr;
    logic         clip_rd_en;
    logic [143:0] clip_obj_in;
    logic         obj_valid;
    logic         obj_ready;
    logic [143:0] obj_data;
    logic [15:0]  bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax;
    logic         busy;
    logic         done;
    logic [5:0]   accept_cnt;
    logic [5:0]   reject_cnt;

    clip_obj_fetch #(.SCREEN_W(W), .SCREEN_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .obj_count(obj_count),
        .clip_addr(clip_addr), .clip_rd_en(clip_rd_en), .clip_obj_in(clip_obj_in),
        .obj_valid(obj_valid), .obj_ready(obj_ready), .obj_data(obj_data),
        .bbox_xmin(bbox_xmin), .bbox_xmax(bbox_xmax),
        .bbox_ymin(bbox_ymin), .bbox_ymax(bbox_ymax),
        .busy(busy), .done(done), .accept_cnt(accept_cnt), .reject_cnt(reject_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Object memory with a one-cycle registered read.
    logic [143:0] mem [32];
    always @(posedge clk) begin
        if (clip_rd_en) clip_obj_in <= mem[clip_addr];
    end

    typedef struct {
        logic [143:0] data;
        logic [63:0]  bbox;
    } exp_t;

    exp_t exp_obj[$];
    int   exp_addr[$];
    int   exp_acc, exp_rej;
    int   errors = 0;
    int   checks = 0;

    int cyc = 0, start_cyc = 0;
    int first_rd_rel, first_valid_rel, done_rel;
    int rd_cnt, hs_cnt, stall_cnt, done_cnt = 0, done_base;
    logic [63:0]  last_bbox;
    logic         prev_valid, prev_ready, prev_done;
    logic [143:0] prev_data;
    logic [63:0]  prev_bbox;

    task automatic check(input string name, input logic [143:0] got, input logic [143:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic logic [143:0] mk(input int x0, input int x1, input int x2, input int x3,
                                        input int y0, input int y1, input int y2, input int y3,
                                        input int typ);
        logic [143:0] w;
        w = '0;
        w[15:0]    = 16'(x0);  w[31:16]   = 16'(y0);
        w[47:32]   = 16'(x1);  w[63:48]   = 16'(y1);
        w[79:64]   = 16'(x2);  w[95:80]   = 16'(y2);
        w[111:96]  = 16'(x3);  w[127:112] = 16'(y3);
        w[139:128] = 12'h5A5 ^ 12'(x0 + y3);
        w[143:140] = 4'(typ);
        return w;
    endfunction

    function automatic int clampv(input int v, input int lim);
`ifdef CLIP_CLAMP_EN
        if (v < 0) return 0;
        if (v > lim - 1) return lim - 1;
`endif
        return v;
    endfunction

    // Model: which slots are read, which objects come out, final counters.
    task automatic build_model(input int cnt);
        int n;
        n = (cnt > 32) ? 32 : cnt;
        exp_obj.delete();
        exp_addr.delete();
        exp_acc = 0;
        exp_rej = 0;
        for (int i = 0; i < n; i++) begin
            logic [143:0] w;
            int xs[4], ys[4];
            int xmn, xmx, ymn, ymx;
            exp_t e;
            exp_addr.push_back(i);
            w = mem[i];
            if (w[143:140] == 4'd0) continue;
            for (int k = 0; k < 4; k++) begin
                xs[k] = int'($signed(w[32*k +: 16]));
                ys[k] = int'($signed(w[32*k+16 +: 16]));
            end
            xmn = xs[0]; xmx = xs[0]; ymn = ys[0]; ymx = ys[0];
            for (int k = 1; k < 4; k++) begin
                if (xs[k] < xmn) xmn = xs[k];
                if (xs[k] > xmx) xmx = xs[k];
                if (ys[k] < ymn) ymn = ys[k];
                if (ys[k] > ymx) ymx = ys[k];
            end
            if (xmx < 0 || xmn >= W || ymx < 0 || ymn >= H) begin
                exp_rej++;
            end else begin
                exp_acc++;
                e.data = w;
                e.bbox = {16'(clampv(xmn, W)), 16'(clampv(xmx, W)),
                          16'(clampv(ymn, H)), 16'(clampv(ymx, H))};
                exp_obj.push_back(e);
            end
        end
        first_rd_rel = -1;
        first_valid_rel = -1;
        done_rel = -1;
        rd_cnt = 0;
        hs_cnt = 0;
        stall_cnt = 0;
        done_base = done_cnt;
    endtask

    // Cycle counter; remembers the edge at which a start was honoured.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst_n && start && !busy) start_cyc = cyc;
    end

    // Compare process: checks every read, handshake, stall and done pulse.
    always @(negedge clk) begin
        int rel;
        exp_t e;
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            prev_done  = 1'b0;
        end else begin
            rel = cyc - start_cyc + 1;
            if (clip_rd_en) begin
                rd_cnt++;
                if (first_rd_rel < 0) first_rd_rel = rel;
                if (exp_addr.size() == 0)
                    check("spurious_read", 144'(clip_rd_en), 144'(0));
                else
                    check("clip_addr", 144'(clip_addr), 144'(exp_addr.pop_front()));
            end
            if (obj_valid) begin
                if (first_valid_rel < 0) first_valid_rel = rel;
                if (prev_valid && !prev_ready) begin
                    check("hold_data", obj_data, prev_data);
                    check("hold_bbox", 144'({bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax}), 144'(prev_bbox));
                end
                if (!obj_ready) begin
                    stall_cnt++;
                end else begin
                    hs_cnt++;
                    last_bbox = {bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax};
                    if (exp_obj.size() == 0) begin
                        check("extra_handshake", 144'(obj_valid), 144'(0));
                    end else begin
                        e = exp_obj.pop_front();
                        check("obj_data", obj_data, e.data);
                        check("bbox", 144'(last_bbox), 144'(e.bbox));
                        $display("handshake: data=%0h bbox=%0h", obj_data, last_bbox);
                    end
                end
            end
            if (done) begin
                if (prev_done) check("done_width", 144'(done), 144'(0));
                done_cnt++;
                done_rel = rel;
            end
            prev_valid = obj_valid;
            prev_ready = obj_ready;
            prev_done  = done;
            prev_data  = obj_data;
            prev_bbox  = {bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax};
        end
    end

    task automatic pulse_start(input int cnt);
        @(posedge clk);
        #1 obj_count = 6'(cnt);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Wait (bounded) for the pass to end, then check the pass totals.
    task automatic finish_pass(input string name);
        int n;
        n = 0;
        while (done_cnt == done_base && n < 400) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check({name, "_done_count"}, 144'(done_cnt - done_base), 144'(1));
        check({name, "_accept_cnt"}, 144'(accept_cnt), 144'(exp_acc));
        check({name, "_reject_cnt"}, 144'(reject_cnt), 144'(exp_rej));
        check({name, "_objs_left"}, 144'(exp_obj.size()), 144'(0));
        check({name, "_reads_left"}, 144'(exp_addr.size()), 144'(0));
        check({name, "_busy_after"}, 144'(busy), 144'(0));
        $display("pass %s: accept=%0d reject=%0d handshakes=%0d reads=%0d", name, accept_cnt, reject_cnt, hs_cnt, rd_cnt);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) mem[i] = '0;
    endtask

    initial begin
        int n;
        rst_n = 1'b1;
        start = 1'b0;
        obj_count = 6'd0;
        obj_ready = 1'b1;
        clip_obj_in = '0;
        clear_mem();
        #2 rst_n = 1'b0;
        #10;
        check("rst_busy", 144'(busy), 144'(0));
        check("rst_outputs", 144'({obj_valid, done, clip_rd_en, clip_addr, accept_cnt, reject_cnt}), 144'(0));
        check("rst_obj_data", obj_data, 144'(0));
        check("rst_bbox", 144'({bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax}), 144'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: empty pass
        build_model(0);
        pulse_start(0);
        finish_pass("count0");
        check("count0_done_rel", 144'(done_rel), 144'(1));
        check("count0_reads", 144'(rd_cnt), 144'(0));

        // 2: single visible object, ready held high
        mem[0] = mk(10, 20, 30, 40, 5, 6, 7, 8, 1);
        build_model(1);
        pulse_start(1);
        finish_pass("single");
        check("single_rd_rel", 144'(first_rd_rel), 144'(1));
        check("single_valid_rel", 144'(first_valid_rel), 144'(3));
        check("single_done_rel", 144'(done_rel), 144'(4));
        check("single_bbox_lit", 144'(last_bbox), 144'({16'd10, 16'd40, 16'd5, 16'd8}));

        // 3: trivial rejects, left of screen and below screen
        mem[0] = mk(-5, -4, -2, -1, 10, 20, 30, 40, 2);
        build_model(1);
        pulse_start(1);
        finish_pass("rej_left");
        check("rej_left_lit", 144'({accept_cnt, reject_cnt, 6'(hs_cnt)}), 144'({6'd0, 6'd1, 6'd0}));
        mem[0] = mk(10, 20, 30, 40, 480, 480, 480, 480, 3);
        build_model(1);
        pulse_start(1);
        finish_pass("rej_bottom");
        check("rej_bottom_lit", 144'(reject_cnt), 144'(1));

        // 4: empty slot between two visible objects
        mem[0] = mk(0, 1, 2, 3, 0, 1, 2, 3, 1);
        mem[1] = mk(-100, -100, -100, -100, 0, 0, 0, 0, 0);
        mem[2] = mk(639, 639, 600, 600, 479, 400, 479, 400, 7);
        build_model(3);
        pulse_start(3);
        finish_pass("skip_empty");
        check("skip_empty_hs", 144'(hs_cnt), 144'(2));
        check("skip_empty_reads", 144'(rd_cnt), 144'(3));

        // 5: stall for 5 cycles with a start pulse that must be ignored
        clear_mem();
        mem[0] = mk(100, 200, 150, 120, 50, 60, 70, 80, 4);
        obj_ready = 1'b0;
        build_model(1);
        pulse_start(1);
        n = 0;
        while (!obj_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("stall_valid_seen", 144'(obj_valid), 144'(1));
        repeat (4) begin
            @(posedge clk);
            if (stall_cnt == 2) begin
                #1 start = 1'b1;
                obj_count = 6'd1;
            end else begin
                #1 start = 1'b0;
            end
        end
        start = 1'b0;
        @(posedge clk);
        #1 obj_ready = 1'b1;
        finish_pass("stall");
        check("stall_cycles", 144'(stall_cnt), 144'(5));
        check("stall_hs", 144'(hs_cnt), 144'(1));
        check("stall_reads", 144'(rd_cnt), 144'(1));

        // 6: straddling object, bbox clamped only in the clamping build
        mem[0] = mk(-20, 700, 100, 0, -3, 500, 10, 20, 5);
        build_model(1);
        pulse_start(1);
        finish_pass("straddle");
`ifdef CLIP_CLAMP_EN
        check("straddle_bbox_lit", 144'(last_bbox), 144'({16'd0, 16'd639, 16'd0, 16'd479}));
`else
        check("straddle_bbox_lit", 144'(last_bbox), 144'({16'hFFEC, 16'd700, 16'hFFFD, 16'd500}));
`endif

        // Count above 32 clamps to 32 slots, mixed empty/reject/accept
        for (int i = 0; i < 32; i++) begin
            if (i % 3 == 0)
                mem[i] = mk(i, i, i, i, 1, 1, 1, 1, 0);
            else if (i % 4 == 1)
                mem[i] = mk(640 + i, 641, 700, 999, 10, 10, 10, 10, 1);
            else
                mem[i] = mk(i * 10, i * 10 + 5, -i, 3, i, 2 * i, 470, -1, 2);
        end
        build_model(40);
        pulse_start(40);
        finish_pass("clamp32");
        check("clamp32_reads", 144'(rd_cnt), 144'(32));

        // Reset during OUT aborts the pass without a done pulse
        clear_mem();
        mem[0] = mk(10, 20, 30, 40, 5, 6, 7, 8, 1);
        obj_ready = 1'b0;
        build_model(1);
        pulse_start(1);
        n = 0;
        while (!obj_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("abort_valid_seen", 144'(obj_valid), 144'(1));
        #2 rst_n = 1'b0;
        #1;
        check("abort_valid", 144'(obj_valid), 144'(0));
        check("abort_busy", 144'(busy), 144'(0));
        check("abort_counts", 144'({accept_cnt, reject_cnt}), 144'(0));
        check("abort_data", obj_data, 144'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        obj_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_no_done", 144'(done_cnt - done_base), 144'(0));
        check("abort_idle", 144'(busy), 144'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
